// File: rtl/dest_router_if.sv
// Bus bundle for dest_router: the upstream word handshake, the four
// destination FIFO push/backpressure lines, and a debug view of the
// router state.
//
// Handshake: a word moves from upstream into the router at a rising edge
// where valid_in=1 and ready_out=1.
// A destination FIFO takes data_out at every rising edge where its push_Pn=1.
// almost_full_Pn=1 stops the router from pushing into FIFO n.
// It has no effect on the other three FIFOs.
//
// state_dbg encoding: 0 = IDLE, 1 = SEND, 2 = WAIT.
interface dest_router_if;
  logic       valid_in;
  logic [9:0] data_in;
  logic       ready_out;
  logic       almost_full_P0;
  logic       almost_full_P1;
  logic       almost_full_P2;
  logic       almost_full_P3;
  logic       push_P0;
  logic       push_P1;
  logic       push_P2;
  logic       push_P3;
  logic [9:0] data_out;
  logic [1:0] state_dbg;

  // Upstream source plus FIFO side, as seen by whoever drives the router.
  modport master (
    output valid_in, data_in,
    output almost_full_P0, almost_full_P1, almost_full_P2, almost_full_P3,
    input  ready_out,
    input  push_P0, push_P1, push_P2, push_P3,
    input  data_out, state_dbg
  );

  // The router itself.
  modport slave (
    input  valid_in, data_in,
    input  almost_full_P0, almost_full_P1, almost_full_P2, almost_full_P3,
    output ready_out,
    output push_P0, push_P1, push_P2, push_P3,
    output data_out, state_dbg
  );
endinterface

// File: rtl/dest_router.sv
// dest_router: a one-entry buffer that routes each 10-bit word to one of
// four FIFOs.
// data_in[9:8] selects the FIFO and the whole word is forwarded.
// A word accepted at edge k is pushed in cycle k+1 when its FIFO is not
// almost_full.
// If that FIFO is almost_full, the word waits in the buffer and upstream
// sees ready_out=0.
// A push and a new accept can happen at the same edge, which gives one word
// per cycle with no bubble.
// Optional feature macro: ROUTER_STATS_EN adds the push_count and
// stall_cycles counters.
module dest_router (
  input  logic            clk,
  input  logic            reset,
  dest_router_if.slave    bus
`ifdef ROUTER_STATS_EN
  ,
  output logic [7:0]      push_count,
  output logic [7:0]      stall_cycles
`endif
);

  // The registered state records buffer occupancy and whether the word was
  // held at the last edge.
  // The live state below refines it with the current almost_full, so WAIT
  // is left in the same cycle that almost_full drops.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t     state_q, state_d, state_live;
  logic [9:0] buf_q, buf_d;
  logic       buf_valid;
  logic [3:0] af_vec;
  logic       dest_af;
  logic       issue;
  logic       accept;
  logic       ready;
  logic [3:0] push_vec;

  assign af_vec    = {bus.almost_full_P3, bus.almost_full_P2,
                      bus.almost_full_P1, bus.almost_full_P0};
  assign buf_valid = (state_q != ST_IDLE);
  // Only the buffered word's own FIFO matters, so there is no head-of-line
  // coupling to the other FIFOs.
  assign dest_af   = af_vec[buf_q[9:8]];
  assign issue     = buf_valid & ~dest_af & ~reset;
  assign ready     = ~reset & (~buf_valid | issue);
  assign accept    = bus.valid_in & ready;

  // Next buffer contents and state: an accept loads the buffer (and
  // overrides any issue), an issue empties it, otherwise the word is held.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    if (accept) begin
      buf_d   = bus.data_in;
      state_d = ST_SEND;
    end else if (issue) begin
      state_d = ST_IDLE;
    end else if (buf_valid) begin
      state_d = ST_WAIT;
    end
  end

  // State and buffer registers; reset discards any buffered word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      buf_q   <= 10'h000;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
    end
  end

  // Push decode (one-hot at most), data_out and the live debug state.
  always_comb begin
    push_vec   = 4'b0000;
    state_live = ST_IDLE;
    if (issue) begin
      push_vec = 4'b0001 << buf_q[9:8];
    end
    if (buf_valid && !reset) begin
      state_live = dest_af ? ST_WAIT : ST_SEND;
    end
  end

  assign bus.push_P0   = push_vec[0];
  assign bus.push_P1   = push_vec[1];
  assign bus.push_P2   = push_vec[2];
  assign bus.push_P3   = push_vec[3];
  assign bus.data_out  = (buf_valid && !reset) ? buf_q : 10'h000;
  assign bus.ready_out = ready;
  assign bus.state_dbg = state_live;

`ifdef ROUTER_STATS_EN
  logic [7:0] push_count_q;
  logic [7:0] stall_cycles_q;

  // push_count wraps; stall_cycles saturates at 255.
  always_ff @(posedge clk) begin
    if (reset) begin
      push_count_q   <= 8'd0;
      stall_cycles_q <= 8'd0;
    end else begin
      if (issue) begin
        push_count_q <= push_count_q + 8'd1;
      end
      if (buf_valid && dest_af && (stall_cycles_q != 8'hFF)) begin
        stall_cycles_q <= stall_cycles_q + 8'd1;
      end
    end
  end

  assign push_count   = push_count_q;
  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_dest_router.sv
// Testbench for dest_router.
// The reference model is a queue of words that were accepted but not yet
// pushed.
// In every cycle the head of the queue must be pushed to its FIFO unless
// that FIFO is almost_full.
// ready_out must be high when the queue is empty or its head leaves this
// cycle.
// When ROUTER_STATS_EN is defined, the bench also models and checks the
// statistics counters.
module tb_dest_router;

  logic clk;
  logic reset;

  dest_router_if bus ();

`ifdef ROUTER_STATS_EN
  logic [7:0] push_count;
  logic [7:0] stall_cycles;
`endif

  dest_router dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus)
`ifdef ROUTER_STATS_EN
    ,
    .push_count   (push_count),
    .stall_cycles (stall_cycles)
`endif
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  int unsigned test_cnt = 0;
  int unsigned fail_cnt = 0;

  // Scoreboard: words accepted but not yet pushed, in arrival order.
  logic [9:0] exp_q[$];
  int unsigned mdl_push_cnt = 0;
  int unsigned mdl_stall = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    test_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Driver: apply one cycle of inputs, check outputs against the model,
  // then advance the model across the rising edge.
  task automatic step(input logic rst, input logic v, input logic [9:0] d, input logic [3:0] af);
    logic [3:0] exp_push;
    logic [9:0] exp_data;
    logic       exp_rdy;
    logic [1:0] exp_state;
    logic [9:0] head;
    @(negedge clk);
    reset              = rst;
    bus.valid_in       = v;
    bus.data_in        = d;
    bus.almost_full_P0 = af[0];
    bus.almost_full_P1 = af[1];
    bus.almost_full_P2 = af[2];
    bus.almost_full_P3 = af[3];
    #1;
    exp_push  = 4'b0000;
    exp_data  = 10'h000;
    exp_rdy   = 1'b0;
    exp_state = S_IDLE;
    if (!rst) begin
      if (exp_q.size() > 0) begin
        head     = exp_q[0];
        exp_data = head;
        if (!af[head[9:8]]) begin
          exp_push[head[9:8]] = 1'b1;
          exp_state = S_SEND;
        end else begin
          exp_state = S_WAIT;
        end
      end
      exp_rdy = (exp_q.size() == 0) || (exp_push != 4'b0000);
    end
    check_eq("push", {28'd0, bus.push_P3, bus.push_P2, bus.push_P1, bus.push_P0}, {28'd0, exp_push});
    check_eq("data_out", {22'd0, bus.data_out}, {22'd0, exp_data});
    check_eq("ready_out", {31'd0, bus.ready_out}, {31'd0, exp_rdy});
    check_eq("state", {30'd0, bus.state_dbg}, {30'd0, exp_state});
`ifdef ROUTER_STATS_EN
    check_eq("push_count", {24'd0, push_count}, mdl_push_cnt);
    check_eq("stall_cycles", {24'd0, stall_cycles}, mdl_stall);
`endif
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      mdl_push_cnt = 0;
      mdl_stall    = 0;
    end else begin
      if (exp_push != 4'b0000) begin
        void'(exp_q.pop_front());
        mdl_push_cnt = (mdl_push_cnt + 1) % 256;
      end
      if (exp_state == S_WAIT && mdl_stall < 255) mdl_stall++;
      if (v && exp_rdy) exp_q.push_back(d);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 10'h000, 4'b0000);
  endtask

  initial begin
    logic [3:0] af_r;
    reset              = 1'b1;
    bus.valid_in       = 1'b0;
    bus.data_in        = 10'h000;
    bus.almost_full_P0 = 1'b0;
    bus.almost_full_P1 = 1'b0;
    bus.almost_full_P2 = 1'b0;
    bus.almost_full_P3 = 1'b0;

    // Reset state: outputs quiet while reset is high.
    step(1'b1, 1'b1, 10'h155, 4'b0000);
    step(1'b1, 1'b0, 10'h000, 4'b0000);

    // Single word to FIFO 2.
    step(1'b0, 1'b1, 10'h2A5, 4'b0000);
    idle(2);

    // Back-to-back words to all four FIFOs.
    step(1'b0, 1'b1, 10'h011, 4'b0000);
    step(1'b0, 1'b1, 10'h155, 4'b0000);
    step(1'b0, 1'b1, 10'h2AA, 4'b0000);
    step(1'b0, 1'b1, 10'h3FF, 4'b0000);
    idle(2);

    // Destination almost_full: hold in WAIT, then release.
    step(1'b0, 1'b1, 10'h1C3, 4'b0010);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 10'h1C3, 4'b0010);
    step(1'b0, 1'b0, 10'h000, 4'b0000);
    idle(1);

    // A non-destination almost_full is ignored.
    step(1'b0, 1'b1, 10'h0F0, 4'b1000);
    step(1'b0, 1'b0, 10'h000, 4'b1000);
    idle(1);

    // Reset during WAIT discards the buffered word.
    step(1'b0, 1'b1, 10'h2EE, 4'b0100);
    step(1'b0, 1'b0, 10'h000, 4'b0100);
    step(1'b0, 1'b0, 10'h000, 4'b0100);
    step(1'b1, 1'b0, 10'h000, 4'b0100);
    idle(3);

    // Randomized traffic with random backpressure and occasional resets.
    for (int i = 0; i < 600; i++) begin
      af_r = 4'b0000;
      for (int p = 0; p < 4; p++) af_r[p] = ($urandom_range(0, 3) == 0);
      step(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) != 0),
           10'($urandom_range(0, 1023)), af_r);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 10'h000, 4'b0000);
    check_eq("drained", exp_q.size(), 0);

`ifdef ROUTER_STATS_EN
    // 260 stall cycles, then 300 pushes in total.
    step(1'b1, 1'b0, 10'h000, 4'b0000);
    step(1'b0, 1'b1, 10'h001, 4'b0000);
    for (int i = 0; i < 260; i++) step(1'b0, 1'b0, 10'h000, 4'b0001);
    for (int i = 0; i < 299; i++) step(1'b0, 1'b1, 10'($urandom_range(0, 1023)), 4'b0000);
    step(1'b0, 1'b0, 10'h000, 4'b0000);
    #1;
    check_eq("push_count_300", {24'd0, push_count}, 32'd44);
    check_eq("stall_cycles_260", {24'd0, stall_cycles}, 32'd255);
`endif

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/dest_router.md
DEST_ROUTER -- requirements
Module: dest_router

Interface
REQ-001 SHALL have port clk, input, 1 bit; single clock, all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-003 SHALL have port valid_in, input, 1 bit; upstream word valid.
REQ-004 SHALL have port data_in, input, 10 bits; bits [9:8] = destination FIFO index, bits [7:0] = payload.
REQ-005 SHALL have port ready_out, output, 1 bit; word accepted at the edge where valid_in=1 and ready_out=1.
REQ-006 SHALL have ports almost_full_P0..almost_full_P3, input, 1 bit each; backpressure from the four destination FIFOs.
REQ-007 SHALL have ports push_P0..push_P3, output, 1 bit each; write strobe into the destination FIFO.
REQ-008 SHALL have port data_out, output, 10 bits; full word (destination bits included), shared by all four FIFOs, qualified by push_Pn.

Function
REQ-009 SHALL hold one-entry buffer (buf, buf_valid) and FSM with states IDLE (buf_valid=0), SEND (buf_valid=1, dest not almost_full), WAIT (buf_valid=1, dest almost_full).
REQ-010 SHALL define issue = buf_valid AND NOT almost_full_P[buf[9:8]], evaluated combinationally in the current cycle.
REQ-011 SHALL drive push_Pd = issue AND (buf[9:8]==d); at most one push_Pn high per cycle.
REQ-012 SHALL drive data_out = buf whenever buf_valid=1, else 10'h000.
REQ-013 SHALL drive ready_out = NOT reset AND (NOT buf_valid OR issue).
REQ-014 On accept edge: buf<=data_in, buf_valid<=1; else on issue edge: buf_valid<=0; else hold.
REQ-015 Latency: word accepted at edge k SHALL push in cycle k+1 if its destination is not almost_full; sustained throughput one word per cycle.
REQ-016 WAIT: buf, data_out, and all push_Pn = 0 held unchanged; ready_out=0; exits to SEND the cycle the destination almost_full drops.
REQ-017 almost_full of non-destination FIFOs SHALL have no effect (no head-of-line dependency on other ports).
REQ-018 Simultaneous issue and accept: old word pushed, new word loaded same edge, no bubble.
REQ-019 Words SHALL never be dropped, duplicated, or reordered.

Reset
REQ-020 reset=1 at an edge SHALL clear buf to 10'h000, buf_valid to 0, FSM to IDLE, stats counters to 0.
REQ-021 During reset: push_P0..P3=0, data_out=10'h000, ready_out=0.
REQ-022 Reset mid-operation (SEND or WAIT) SHALL discard the buffered word with no push emitted.

Configuration
REQ-023 Macro ROUTER_STATS_EN: when defined, SHALL add outputs push_count (8 bits, increments per push, wraps 255->0) and stall_cycles (8 bits, increments each cycle in WAIT, saturates at 255).
REQ-024 Without ROUTER_STATS_EN: those ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-025 Reset then valid_in=1, data_in=10'h2A5, all almost_full=0 -> next cycle push_P2=1, data_out=10'h2A5, others 0.
REQ-026 Back-to-back words 10'h011, 10'h155, 10'h2AA, 10'h3FF -> push_P0,P1,P2,P3 in four consecutive cycles, ready_out stays 1.
REQ-027 almost_full_P1=1, send 10'h1C3 for 3 cycles -> WAIT, ready_out=0, no push; deassert -> push_P1=1 with 10'h1C3 next cycle.
REQ-028 almost_full_P3=1 while sending 10'h0F0 -> push_P0=1 immediately (no dependency on P3).
REQ-029 reset pulse during WAIT with buf=10'h2EE -> no push ever for 10'h2EE; outputs zero; ready_out=1 after reset deasserts.
REQ-030 With ROUTER_STATS_EN: 300 pushes and 260 WAIT cycles -> push_count=44, stall_cycles=255.
